// File: rtl/hazard_scoreboard.sv
// Decode-stage data-hazard unit: a shift-register scoreboard of in-flight register
// writers. It stalls decode on read-after-write, either full interlock or load-use only.
module hazard_scoreboard #(
    parameter int DEPTH  = 2,
    parameter int FWD_EN = 0,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      instr,
    input  logic             instr_valid,
    input  logic             dst_we,
    input  logic [2:0]       dst_reg,
    input  logic             dst_is_load,
    input  logic             flush,
    output logic             stall,
    output logic             issue,
    output logic [DEPTH-1:0] sb_valid,
    output logic [CNT_W-1:0] stall_count
);

    // Handshake: decode offers an instruction with instr_valid; it leaves decode
    // (issue) only in a cycle where stall is low and flush is low. While stall is
    // high, the upstream stage must hold instr/instr_valid stable.

    logic [4:0]       opcode;
    logic [2:0]       rs;
    logic [2:0]       rt;
    logic             rs_used;
    logic             rt_used;
    logic [DEPTH-1:0] v_q;
    logic [2:0]       reg_q [DEPTH];
    logic             ld0_q;
    logic [DEPTH-1:0] match;
    logic             stall_any;
    logic             stall_ld;
    logic [CNT_W-1:0] cnt_q;
    logic             unused_instr;

    assign opcode       = instr[15:11];
    assign rs           = instr[10:8];
    assign rt           = instr[7:5];
    assign unused_instr = ^instr[4:0];

    always_comb begin
        rs_used = 1'b1;
        rt_used = 1'b0;
        case (opcode)
            5'b00000, 5'b00001, 5'b00100, 5'b00110, 5'b11000: rs_used = 1'b0;
            default:                                          rs_used = 1'b1;
        endcase
        if ((opcode[4:3] == 2'b11 && opcode != 5'b11001) ||
            opcode == 5'b10000 || opcode == 5'b10011)
            rt_used = 1'b1;
    end

    // Only stage 0's load flag matters: forwarding covers every later stage.
    always_comb begin
        match = '0;
        for (int k = 0; k < DEPTH; k++) begin
            match[k] = v_q[k] & ((rs_used & (reg_q[k] == rs)) |
                                 (rt_used & (reg_q[k] == rt)));
        end
        stall_any = instr_valid & (|match);
        stall_ld  = instr_valid & match[0] & ld0_q;
        stall     = (FWD_EN != 0) ? stall_ld : stall_any;
        issue     = instr_valid & ~stall & ~flush;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q   <= '0;
            ld0_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            for (int k = 1; k < DEPTH; k++) begin
                v_q[k]   <= v_q[k-1];
                reg_q[k] <= reg_q[k-1];
            end
            v_q[0]   <= issue & dst_we;
            reg_q[0] <= dst_reg;
            ld0_q    <= issue & dst_we & dst_is_load;
            if (stall && !flush && cnt_q != {CNT_W{1'b1}})
                cnt_q <= cnt_q + 1'b1;
        end
    end

    assign sb_valid    = v_q;
    assign stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: three instances (interlock, load-use forwarding,
// 4-bit counter) share one decode stream; hand-computed expectations.
module tb_hazard_scoreboard;

    logic        clk;
    logic        rst_n;
    logic [15:0] instr;
    logic        instr_valid;
    logic        dst_we;
    logic [2:0]  dst_reg;
    logic        dst_is_load;
    logic        flush;

    logic        stall0, issue0, stall1, issue1, stall2, issue2;
    logic [1:0]  sbv0, sbv1, sbv2;
    logic [15:0] cnt0, cnt1;
    logic [3:0]  cnt2;

    int total_cnt;
    int bad_cnt;
    logic [31:0] exp_q[$];

    hazard_scoreboard #(.DEPTH(2), .FWD_EN(0), .CNT_W(16)) u_int (
        .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
        .dst_we(dst_we), .dst_reg(dst_reg), .dst_is_load(dst_is_load), .flush(flush),
        .stall(stall0), .issue(issue0), .sb_valid(sbv0), .stall_count(cnt0));

    hazard_scoreboard #(.DEPTH(2), .FWD_EN(1), .CNT_W(16)) u_fwd (
        .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
        .dst_we(dst_we), .dst_reg(dst_reg), .dst_is_load(dst_is_load), .flush(flush),
        .stall(stall1), .issue(issue1), .sb_valid(sbv1), .stall_count(cnt1));

    hazard_scoreboard #(.DEPTH(2), .FWD_EN(0), .CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
        .dst_we(dst_we), .dst_reg(dst_reg), .dst_is_load(dst_is_load), .flush(flush),
        .stall(stall2), .issue(issue2), .sb_valid(sbv2), .stall_count(cnt2));

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] i, input logic v, input logic we,
                         input logic [2:0] dr, input logic ld, input logic fl);
        instr       = i;
        instr_valid = v;
        dst_we      = we;
        dst_reg     = dr;
        dst_is_load = ld;
        flush       = fl;
        #1;
    endtask

    task automatic idle();
        drive(16'h0800, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    function automatic logic issue_of(input int w);
        case (w)
            0:       return issue0;
            1:       return issue1;
            default: return issue2;
        endcase
    endfunction

    // Counts stall cycles on instance w until the decode instruction issues.
    task automatic expect_stalls(input string tag, input int w, input int exp);
        int n;
        exp_q.push_back(exp);
        n = 0;
        while (!issue_of(w) && n < 8) begin
            n++;
            tick();
        end
        check_eq(tag, n, exp_q.pop_front());
    endtask

    initial begin
        total_cnt = 0;
        bad_cnt   = 0;
        rst_n     = 1'b1;
        idle();

        // reset state
        do_reset();
        check_eq("reset_sbv", sbv0, 0);
        check_eq("reset_cnt", cnt0, 0);
        check_eq("reset_stall", stall0, 0);

        // ADD r3 then dependent ADD r4,r3,r1: two stalls under interlock
        drive(16'hD94C, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0);
        check_eq("writer_issue", issue0, 1);
        tick();
        drive(16'hDB30, 1'b1, 1'b0, 3'd4, 1'b0, 1'b0);
        check_eq("raw_stall_c1", stall0, 1);
        check_eq("raw_sbv_c1", sbv0, 2'b01);
        check_eq("fwd_nonload_no_stall", stall1, 0);
        expect_stalls("raw_len", 0, 2);
        tick();
        check_eq("raw_cnt", cnt0, 2);

        // LBI r3 does not read r3; ST reading r3 via Rt stalls twice
        do_reset();
        drive(16'hD94C, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0);
        tick();
        drive(16'hC312, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0);
        check_eq("lbi_stall", stall0, 0);
        check_eq("lbi_issue", issue0, 1);
        tick();
        drive(16'h8160, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        expect_stalls("st_rt_len", 0, 2);
        tick();

        // load-use with forwarding: one stall; non-load writer: none
        do_reset();
        drive(16'h8BA0, 1'b1, 1'b1, 3'd5, 1'b1, 1'b0);
        tick();
        drive(16'hD9B8, 1'b1, 1'b0, 3'd6, 1'b0, 1'b0);
        expect_stalls("ld_use_len", 1, 1);
        tick();
        check_eq("ld_use_cnt", cnt1, 1);
        do_reset();
        drive(16'h8BA0, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0);
        tick();
        drive(16'hD9B8, 1'b1, 1'b0, 3'd6, 1'b0, 1'b0);
        check_eq("int_nonload_stall", stall0, 1);
        expect_stalls("nonload_len", 1, 0);
        tick();

        // flush over a stall: no issue, no count, stage 0 squashed
        do_reset();
        drive(16'hD94C, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0);
        tick();
        drive(16'hDB30, 1'b1, 1'b0, 3'd4, 1'b0, 1'b1);
        check_eq("flush_stall", stall0, 1);
        check_eq("flush_issue", issue0, 0);
        tick();
        check_eq("flush_cnt", cnt0, 0);
        check_eq("flush_sbv", sbv0, 2'b10);
        drive(16'hDB30, 1'b1, 1'b0, 3'd4, 1'b0, 1'b0);
        expect_stalls("post_flush_len", 0, 1);
        tick();
        check_eq("post_flush_cnt", cnt0, 1);

        // self-dependent writer: issue, stall, stall repeating; 4-bit counter saturates
        do_reset();
        drive(16'hDB30, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0);
        check_eq("self_no_stall", stall0, 0);
        for (int i = 0; i < 24; i++) tick();
        check_eq("sat_ref_cnt24", cnt0, 16);
        check_eq("sat_cnt24", cnt2, 4'hF);
        for (int i = 0; i < 9; i++) tick();
        check_eq("sat_ref_cnt33", cnt0, 22);
        check_eq("sat_cnt33", cnt2, 4'hF);

        // reset in the middle of a stall
        do_reset();
        drive(16'hD94C, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0);
        tick();
        drive(16'hDB30, 1'b1, 1'b0, 3'd4, 1'b0, 1'b0);
        tick();
        check_eq("mid_stall", stall0, 1);
        check_eq("mid_cnt", cnt0, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        check_eq("rst_sbv", sbv0, 0);
        check_eq("rst_cnt", cnt0, 0);
        check_eq("rst_stall", stall0, 0);
        check_eq("rst_issue", issue0, 1);

        idle();
        tick();
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
